// File: rtl/alu_sequencer.sv
// alu_sequencer: two-state instruction sequencer wrapped around an external ALU.
//
// Accepts one instruction at a time from a valid/ready handshake. It reads two
// operands from a 4-entry register file and drives them, with the opcode, to
// the external ALU. One cycle later it samples the ALU result, writes it back
// to the destination register and reports completion.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr_valid/ready   instruction handshake (ready only while idle)
//   instr_op/rd/rs/rt   opcode, destination and source register indices
//   wr_en/addr/data     direct register load port, usable in any state
//   ALUOp, R2, R3       opcode and operands to the ALU, held while idle
//   R1, c_out, c_out2   ALU result and add/subtract carry-outs
//   res_valid/data/flag one-cycle completion report with result and carry flag
//   err                 pulses with res_valid for an illegal opcode
//   instr_count         count of completed legal instructions (wraps)

module alu_sequencer #(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [2:0]   instr_op,
    input  logic [1:0]   instr_rd,
    input  logic [1:0]   instr_rs,
    input  logic [1:0]   instr_rt,
    input  logic         wr_en,
    input  logic [1:0]   wr_addr,
    input  logic [n-1:0] wr_data,
    output logic [2:0]   ALUOp,
    output logic [n-1:0] R2,
    output logic [n-1:0] R3,
    input  logic [n-1:0] R1,
    input  logic         c_out,
    input  logic         c_out2,
    output logic         res_valid,
    output logic [n-1:0] res_data,
    output logic         res_flag,
    output logic         err,
    output logic [7:0]   instr_count
);

    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;
    localparam logic [2:0] OpIll = 3'b111;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e         state_q, state_d;
    logic [n-1:0]   rf_q [4];
    logic [1:0]     rd_q;
    logic [2:0]     alu_op_q;
    logic [n-1:0]   r2_q, r3_q;
    logic           res_valid_q, res_flag_q, err_q;
    logic [n-1:0]   res_data_q;
    logic [7:0]     count_q;
    logic           accept;
    logic           exec;

    assign accept = instr_valid && (state_q == StIdle);
    assign exec   = (state_q == StExec);

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = StExec;
            end
            StExec:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Datapath: register file, ALU operand latches and completion report
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
            rd_q        <= '0;
            alu_op_q    <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flag_q  <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;

            if (wr_en) rf_q[wr_addr] <= wr_data;

            // Operands use rf_q before this edge's writes take effect.
            if (accept) begin
                alu_op_q <= instr_op;
                r2_q     <= rf_q[instr_rs];
                r3_q     <= rf_q[instr_rt];
                rd_q     <= instr_rd;
            end

            if (exec) begin
                res_valid_q <= 1'b1;
                if (alu_op_q == OpIll) begin
                    err_q      <= 1'b1;
                    res_flag_q <= 1'b0;
                end else begin
                    // Placed after the wr_en write so writeback wins on a collision.
                    rf_q[rd_q] <= R1;
                    res_data_q <= R1;
                    res_flag_q <= (alu_op_q == OpAdd) ? c_out :
                                  (alu_op_q == OpSub) ? c_out2 : 1'b0;
                    count_q    <= count_q + 8'd1;
                end
            end
        end
    end

    assign ALUOp       = alu_op_q;
    assign R2          = r2_q;
    assign R3          = r3_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_flag    = res_flag_q;
    assign err         = err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed literal checks plus randomized traffic,
// all compared every cycle against a transaction-level model.

module tb_alu_sequencer;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [2:0]   instr_op = '0;
    logic [1:0]   instr_rd = '0, instr_rs = '0, instr_rt = '0;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_addr = '0;
    logic [N-1:0] wr_data = '0;
    logic [2:0]   ALUOp;
    logic [N-1:0] R2, R3, R1;
    logic         c_out, c_out2;
    logic         res_valid, res_flag, err;
    logic [N-1:0] res_data;
    logic [7:0]   instr_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    alu_sequencer #(.n(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs    (instr_rs),
        .instr_rt    (instr_rt),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ALUOp       (ALUOp),
        .R2          (R2),
        .R3          (R3),
        .R1          (R1),
        .c_out       (c_out),
        .c_out2      (c_out2),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_flag    (res_flag),
        .err         (err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Ideal ALU; an illegal opcode yields a marker so res_data holding is visible.
    function automatic logic [7:0] ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return 8'(a);
            1:       return 8'(255 - a);
            2:       return 8'((a + b) % 256);
            3:       return 8'((a - b + 256) % 256);
            4:       return 8'(a | b);
            5:       return 8'(a & b);
            6:       return (a < b) ? 8'd1 : 8'd0;
            default: return 8'h5A;
        endcase
    endfunction

    assign R1     = ref_alu(int'(ALUOp), int'(R2), int'(R3));
    assign c_out  = (int'(R2) + int'(R3)) > 255;
    assign c_out2 = (R2 >= R3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: at most one instruction in flight.
    int  m_regs [4];
    int  m_nxt  [4];
    bit  m_busy = 1'b0;
    int  m_op = 0, m_a = 0, m_b = 0, m_rd = 0;
    int  m_res_data = 0, m_count = 0;
    bit  m_res_valid = 1'b0, m_res_flag = 1'b0, m_err = 1'b0;
    int  m_res;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            m_busy = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0;
            m_res_data = 0; m_count = 0;
            m_res_valid = 0; m_res_flag = 0; m_err = 0;
        end else begin
            for (int i = 0; i < 4; i++) m_nxt[i] = m_regs[i];
            if (wr_en) m_nxt[wr_addr] = int'(wr_data);
            m_res_valid = 0;
            m_err       = 0;
            if (m_busy) begin
                m_busy      = 0;
                m_res_valid = 1;
                if (m_op == 7) begin
                    m_err      = 1;
                    m_res_flag = 0;
                end else begin
                    m_res        = int'(ref_alu(m_op, m_a, m_b));
                    m_nxt[m_rd]  = m_res;
                    m_res_data   = m_res;
                    m_res_flag   = (m_op == 2) ? (m_a + m_b > 255) :
                                   (m_op == 3) ? (m_a >= m_b) : 1'b0;
                    m_count      = (m_count + 1) % 256;
                end
            end else if (instr_valid) begin
                m_busy = 1;
                m_op   = int'(instr_op);
                m_a    = m_regs[instr_rs];
                m_b    = m_regs[instr_rt];
                m_rd   = int'(instr_rd);
            end
            for (int i = 0; i < 4; i++) m_regs[i] = m_nxt[i];
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("instr_ready", 32'(instr_ready), 32'(!m_busy));
            check("ALUOp",       32'(ALUOp),       32'(m_op));
            check("R2",          32'(R2),          32'(m_a));
            check("R3",          32'(R3),          32'(m_b));
            check("res_valid",   32'(res_valid),   32'(m_res_valid));
            check("res_data",    32'(res_data),    32'(m_res_data));
            check("res_flag",    32'(res_flag),    32'(m_res_flag));
            check("err",         32'(err),         32'(m_err));
            check("instr_count", 32'(instr_count), 32'(m_count));
        end
    end

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns at the negedge after the accept edge (operands visible).
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt);
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_aluop", 32'(ALUOp), 32'd0);

        // ADD 5 + 3 into r0
        wr_reg(2'd1, 8'h05);
        wr_reg(2'd2, 8'h03);
        issue(3'b010, 2'd0, 2'd1, 2'd2);
        check("add_aluop", 32'(ALUOp), 32'h2);
        check("add_r2", 32'(R2), 32'h05);
        check("add_r3", 32'(R3), 32'h03);
        check("add_busy", 32'(instr_ready), 32'd0);
        @(negedge clk);
        check("add_valid", 32'(res_valid), 32'd1);
        check("add_data", 32'(res_data), 32'h08);
        check("add_flag", 32'(res_flag), 32'd0);
        check("add_count", 32'(instr_count), 32'd1);
        issue(3'b000, 2'd3, 2'd0, 2'd0);
        check("r0_after_add", 32'(R2), 32'h08);
        @(negedge clk);
        check("mov_count", 32'(instr_count), 32'd2);

        // ADD overflow
        wr_reg(2'd1, 8'hFF);
        wr_reg(2'd2, 8'h01);
        issue(3'b010, 2'd0, 2'd1, 2'd2);
        @(negedge clk);
        check("ovf_data", 32'(res_data), 32'h00);
        check("ovf_flag", 32'(res_flag), 32'd1);
        check("ovf_count", 32'(instr_count), 32'd3);

        // SUB and SLT with 3, 5
        wr_reg(2'd1, 8'h03);
        wr_reg(2'd2, 8'h05);
        issue(3'b011, 2'd0, 2'd1, 2'd2);
        @(negedge clk);
        check("sub_data", 32'(res_data), 32'hFE);
        check("sub_flag", 32'(res_flag), 32'd0);
        issue(3'b110, 2'd3, 2'd1, 2'd2);
        @(negedge clk);
        check("slt_data", 32'(res_data), 32'h01);
        check("slt_count", 32'(instr_count), 32'd5);

        // Illegal opcode
        issue(3'b111, 2'd1, 2'd1, 2'd2);
        @(negedge clk);
        check("ill_err", 32'(err), 32'd1);
        check("ill_valid", 32'(res_valid), 32'd1);
        check("ill_data", 32'(res_data), 32'h01);
        check("ill_flag", 32'(res_flag), 32'd0);
        check("ill_count", 32'(instr_count), 32'd5);
        @(negedge clk);
        check("ill_err_pulse", 32'(err), 32'd0);
        check("ill_valid_pulse", 32'(res_valid), 32'd0);
        issue(3'b000, 2'd2, 2'd1, 2'd1);
        check("ill_r1_kept", 32'(R2), 32'h03);
        @(negedge clk);

        // Back-to-back with instr_valid held: MOV r0<-r3 (01), then NOT r1<-~r2 (r2=03)
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'b000; instr_rd = 2'd0; instr_rs = 2'd3; instr_rt = 2'd3;
        check("held_ready0", 32'(instr_ready), 32'd1);
        @(negedge clk);
        check("held_ready1", 32'(instr_ready), 32'd0);
        check("held_mov_r2", 32'(R2), 32'h01);
        instr_op = 3'b001; instr_rd = 2'd1; instr_rs = 2'd2; instr_rt = 2'd2;
        @(negedge clk);
        check("held_ready2", 32'(instr_ready), 32'd1);
        check("held_res1", 32'(res_data), 32'h01);
        check("held_cnt1", 32'(instr_count), 32'd7);
        @(negedge clk);
        instr_valid = 1'b0;
        check("held_ready3", 32'(instr_ready), 32'd0);
        check("held_not_op", 32'(ALUOp), 32'h1);
        @(negedge clk);
        check("held_res2", 32'(res_data), 32'hFC);
        check("held_cnt2", 32'(instr_count), 32'd8);

        // Writeback collides with wr_en on r0: r1=FC + r2=03 = FF must win over AA
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'b010; instr_rd = 2'd0; instr_rs = 2'd1; instr_rt = 2'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        check("col_data", 32'(res_data), 32'hFF);
        issue(3'b000, 2'd3, 2'd0, 2'd0);
        check("col_r0", 32'(R2), 32'hFF);
        @(negedge clk);

        // Reset while in EXEC abandons the instruction
        issue(3'b010, 2'd2, 2'd1, 2'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rx_valid", 32'(res_valid), 32'd0);
        check("rx_err", 32'(err), 32'd0);
        check("rx_data", 32'(res_data), 32'd0);
        check("rx_r2", 32'(R2), 32'd0);
        check("rx_count", 32'(instr_count), 32'd0);
        check("rx_ready", 32'(instr_ready), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 59) == 0);
            instr_valid = ($urandom_range(0, 9) < 6);
            instr_op    = 3'($urandom_range(0, 7));
            instr_rd    = 2'($urandom_range(0, 3));
            instr_rs    = 2'($urandom_range(0, 3));
            instr_rt    = 2'($urandom_range(0, 3));
            wr_en       = ($urandom_range(0, 9) < 3);
            wr_addr     = 2'($urandom_range(0, 3));
            wr_data     = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        rst = 1'b0; instr_valid = 1'b0; wr_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
